// File: rtl/i2c_mst_seq.sv
// I2C master byte sequencer: pops {start,stop,data} command words, drives a
// bit-level SCL/SDA engine one command at a time and pushes received bytes.
module i2c_mst_seq #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          tx_empty,
  output logic          tx_rd,
  input  logic [9:0]    tx_dat,
  input  logic          rx_full,
  output logic          rx_wr,
  output logic [7:0]    rx_dat,
  output logic          bit_req,
  output logic [CW-1:0] bit_cmd,
  output logic          bit_wdat,
  input  logic          bit_done,
  input  logic          bit_rdat,
  input  logic          bit_al,
  output logic          busy,
  output logic          irq_nas,
  output logic          irq_al,
  output logic          irq_done
);

  localparam logic [CW-1:0] CMD_START  = CW'(0);
  localparam logic [CW-1:0] CMD_RSTART = CW'(1);
  localparam logic [CW-1:0] CMD_STOP   = CW'(2);
  localparam logic [CW-1:0] CMD_WRITE  = CW'(3);
  localparam logic [CW-1:0] CMD_READ   = CW'(4);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_SBIT, S_WBIT, S_WACK, S_RCNT,
    S_RBIT, S_RPUSH, S_RACK, S_STOP, S_HOLD
  } state_t;

  state_t      state;
  logic        owned;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic [7:0]  rcnt;
  logic [9:0]  word;
  logic        after_start;
  logic        stop_save;

  logic [7:0]    wbyte;
  logic [7:0]    rcnt_dec;
  logic [CW-1:0] cmd_code;
  logic          cmd_wdat;
  logic          cmd_state;

  assign wbyte    = word[7:0];
  assign rcnt_dec = rcnt - 8'd1;

  // Bit-command the current state would issue, if it issues one at all.
  always_comb begin
    cmd_code  = CMD_READ;
    cmd_wdat  = 1'b0;
    cmd_state = 1'b1;
    case (state)
      S_SBIT:         cmd_code = owned ? CMD_RSTART : CMD_START;
      S_WBIT: begin
        cmd_code = CMD_WRITE;
        cmd_wdat = wbyte[bitcnt];
      end
      S_WACK, S_RBIT: cmd_code = CMD_READ;
      S_RACK: begin
        cmd_code = CMD_WRITE;
        cmd_wdat = (rcnt == 8'd1);
      end
      S_STOP:         cmd_code = CMD_STOP;
      default:        cmd_state = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      owned       <= 1'b0;
      bitcnt      <= 3'd7;
      shreg       <= '0;
      rcnt        <= '0;
      word        <= '0;
      after_start <= 1'b0;
      stop_save   <= 1'b0;
      tx_rd       <= 1'b0;
      rx_wr       <= 1'b0;
      rx_dat      <= '0;
      bit_req     <= 1'b0;
      bit_cmd     <= '0;
      bit_wdat    <= 1'b0;
      busy        <= 1'b0;
      irq_nas     <= 1'b0;
      irq_al      <= 1'b0;
      irq_done    <= 1'b0;
    end else begin
      tx_rd    <= 1'b0;
      rx_wr    <= 1'b0;
      irq_nas  <= 1'b0;
      irq_al   <= 1'b0;
      irq_done <= 1'b0;
      if (bit_req) begin
        if (bit_done) begin
          bit_req <= 1'b0;
          if (bit_al) begin
            // Lost the bus: walk away silently, FIFO contents untouched.
            irq_al <= 1'b1;
            owned  <= 1'b0;
            busy   <= 1'b0;
            bitcnt <= 3'd7;
            state  <= S_IDLE;
          end else if (state == S_STOP) begin
            owned    <= 1'b0;
            busy     <= 1'b0;
            irq_done <= 1'b1;
            state    <= S_IDLE;
          end else if (!en) begin
            owned  <= 1'b1;
            bitcnt <= 3'd7;
            state  <= S_STOP;
          end else begin
            case (state)
              S_SBIT: begin
                owned  <= 1'b1;
                bitcnt <= 3'd7;
                state  <= S_WBIT;
              end
              S_WBIT: begin
                bitcnt <= bitcnt - 3'd1;
                if (bitcnt == 3'd0) state <= S_WACK;
              end
              S_WACK: begin
                if (bit_rdat) begin
                  irq_nas <= 1'b1;
                  state   <= S_STOP;
                end else if (after_start && word[0]) begin
                  state <= S_RCNT;
                end else if (word[8]) begin
                  state <= S_STOP;
                end else begin
                  state <= S_HOLD;
                end
              end
              S_RBIT: begin
                shreg  <= {shreg[6:0], bit_rdat};
                bitcnt <= bitcnt - 3'd1;
                if (bitcnt == 3'd0) state <= S_RPUSH;
              end
              S_RACK: begin
                rcnt <= rcnt_dec;
                if (rcnt_dec != 8'd0)  state <= S_RBIT;
                else if (stop_save)    state <= S_STOP;
                else                   state <= S_HOLD;
              end
              default: ;
            endcase
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (en && !tx_empty) begin
              tx_rd <= 1'b1;
              word  <= tx_dat;
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (word[9]) begin
              after_start <= 1'b1;
              state       <= S_SBIT;
            end else if (owned) begin
              after_start <= 1'b0;
              state       <= S_WBIT;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_RCNT: begin
            if (!en) begin
              state <= S_STOP;
            end else if (!tx_empty) begin
              tx_rd     <= 1'b1;
              rcnt      <= (tx_dat[7:0] == 8'd0) ? 8'd1 : tx_dat[7:0];
              stop_save <= tx_dat[8];
              state     <= S_RBIT;
            end
          end
          S_RPUSH: begin
            // No bit_req here, so the engine keeps SCL stretched.
            if (!en) begin
              state <= S_STOP;
            end else if (!rx_full) begin
              rx_wr  <= 1'b1;
              rx_dat <= shreg;
              state  <= S_RACK;
            end
          end
          S_HOLD: begin
            if (!en) begin
              state <= S_STOP;
            end else if (!tx_empty) begin
              tx_rd <= 1'b1;
              word  <= tx_dat;
              state <= S_FETCH;
            end
          end
          default: begin
            if (cmd_state) begin
              if (!en && state != S_STOP) begin
                bitcnt <= 3'd7;
                busy   <= owned;
                state  <= owned ? S_STOP : S_IDLE;
              end else begin
                bit_req  <= 1'b1;
                bit_cmd  <= cmd_code;
                bit_wdat <= cmd_wdat;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_mst_seq.md
Name: i2c_mst_seq

Overview:
Byte/command sequencer for the I2C master path, active when cr_msms=1 in the core. Pops 10-bit command words from the TX FIFO, {bit9=start-before, bit8=stop-after, bits7:0=data}. Drives a bit-level SCL/SDA engine one bit-command at a time, and pushes received bytes into the RX FIFO. Reports NACK, arbitration loss and transfer completion as single-cycle pulses.

Parameters:
CW, 3, bit-command code width (fixed encoding below)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  master enable (cr_en & cr_msms)
tx_empty  in  1  TX FIFO empty
tx_rd  out  1  TX FIFO pop; tx_dat is valid whenever !tx_empty (show-ahead)
tx_dat  in  10  TX FIFO head word
rx_full  in  1  RX FIFO full
rx_wr  out  1  RX FIFO push, one cycle
rx_dat  out  8  received byte
bit_req  out  1  bit-command request, held until bit_done
bit_cmd  out  3  0=START 1=RSTART 2=STOP 3=WRITE 4=READ
bit_wdat  out  1  SDA value for WRITE
bit_done  in  1  one-cycle completion of the current bit-command
bit_rdat  in  1  sampled SDA, valid with bit_done
bit_al  in  1  arbitration lost, valid with bit_done
busy  out  1  sequencer owns or is acquiring the bus
irq_nas  out  1  pulse: slave NACKed a written byte
irq_al  out  1  pulse: arbitration lost
irq_done  out  1  pulse: STOP completed normally

Behaviour:
- Reset: all outputs 0. State IDLE. owned=0, bitcnt=7, shreg=0, rcnt=0.
- Single outstanding bit-command. bit_req, bit_cmd and bit_wdat are registered and stable from assertion until the bit_done cycle. bit_req drops the cycle after bit_done.
- States: IDLE, FETCH, SBIT, WBIT, WACK, RCNT, RBIT, RPUSH, RACK, STOP, HOLD.
- IDLE: when en and !tx_empty, go to FETCH.
- FETCH: latch the word, pulse tx_rd, busy=1.
  - If word[9]=1: go to SBIT. SBIT issues START when owned=0, RSTART when owned=1.
  - If word[9]=0 and owned=1: go straight to WBIT.
  - If word[9]=0 and owned=0: drop the word, return to IDLE. No pulse.
- SBIT done: owned=1, go to WBIT.
- WBIT: 8 WRITE commands, MSB first, bitcnt 7 down to 0.
- WACK: one READ command.
  - bit_rdat=1 (NACK): irq_nas pulse, then STOP.
  - bit_rdat=0 (ACK): branch on the byte just written.
    - Byte followed a start and its LSB=1 (read address): go to RCNT.
    - Otherwise word[8]=1: go to STOP.
    - Otherwise: go to HOLD.
- RCNT: wait for !tx_empty, then pop the count word. rcnt = data (0 is treated as 1). Save stop = word[8] of the count word. Go to RBIT.
- RBIT: 8 READ commands, shifted into shreg MSB first. Then go to RPUSH.
- RPUSH: wait while rx_full; no bit_req is issued, so SCL stays stretched by the engine. On !rx_full, rx_wr=1 for one cycle with rx_dat=shreg. Go to RACK.
- RACK: WRITE with bit_wdat=0 if rcnt>1 (ACK), 1 if rcnt==1 (NACK). rcnt decrements 8-bit.
  - rcnt still >0: go to RBIT.
  - Otherwise, saved stop=1: go to STOP.
  - Otherwise: go to HOLD.
- HOLD: bus stays owned, busy=1. Go to FETCH when !tx_empty. Go to STOP if en drops.
- STOP done: owned=0, busy=0, irq_done pulse, go to IDLE.
- Arbitration loss: bit_done with bit_al=1 in any state.
  - irq_al pulse, owned=0, busy=0, go to IDLE. No STOP is issued, and remaining FIFO words are left in place.
  - bit_al has priority over NACK in the same cycle.
- en drop mid-transfer: the current bit-command completes. If owned=1, go to STOP; otherwise go to IDLE. No further tx_rd.
- tx_rd never fires while tx_empty. rx_wr never fires while rx_full.

Test Plan:
- Write of 2 bytes. FIFO holds 0x2A0 (start, addr 0x50 W) then 0x1C3 (stop). Required cmds: START, 8 WRITE (1010_0000), READ, 8 WRITE (1100_0011), READ, STOP. Two tx_rd pulses, irq_done=1.
- Read of 3 bytes. FIFO holds 0x2A1 then 0x103; slave returns 0x11, 0x22, 0x33. Required: rx_wr x3 with those values. ACK, ACK, NACK in the RACK phases, then STOP and irq_done.
- Address NACK. FIFO holds 0x2A0; bit_rdat=1 in WACK. Required: irq_nas one cycle, STOP, no second tx_rd, busy=0 afterwards.
- Repeated start. FIFO holds 0x2A0, 0x010 (no stop), 0x2A1, 0x101. Required: START, then HOLD, then RSTART (not START), 1 byte read, STOP.
- Arbitration lost. bit_al=1 on the 3rd address WRITE done. Required: irq_al pulse, IDLE next cycle, no STOP cmd, owned=0.
- RX backpressure and reset. rx_full=1 for 20 cycles at RPUSH. Required: bit_req=0 and rx_wr=0 throughout, push on release. Then rstn low mid-RBIT: all outputs 0 asynchronously.
